// File: rtl/dpu_cmd_bridge.sv
// dpu_cmd_bridge: turns a host byte stream of WRITE / RUN / READ packets into
// single-byte commands for the layer top, returning read data and status
// bytes on the response stream.
// Optional build macro DPU_BRIDGE_ACK_EN: completed WRITE packets (length 0
// included) answer with status byte 0xA5; without it WRITEs are silent.
module dpu_cmd_bridge #(
    parameter int ADDR_W = 24,
    parameter int LEN_W  = 24
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_data,
    output logic              cmd_valid,
    input  logic              cmd_ready,
    output logic [1:0]        cmd_type,
    output logic [ADDR_W-1:0] cmd_addr,
    output logic [7:0]        cmd_data,
    input  logic              rsp_valid,
    input  logic [7:0]        rsp_data,
    input  logic              dpu_done,
    output logic              busy,
    output logic              err
);

    localparam logic [3:0] S_IDLE     = 4'd0;
    localparam logic [3:0] S_HDR_ADDR = 4'd1;
    localparam logic [3:0] S_HDR_LEN  = 4'd2;
    localparam logic [3:0] S_WR_DATA  = 4'd3;
    localparam logic [3:0] S_WR_CMD   = 4'd4;
    localparam logic [3:0] S_RD_CMD   = 4'd5;
    localparam logic [3:0] S_RD_WAIT  = 4'd6;
    localparam logic [3:0] S_RD_OUT   = 4'd7;
    localparam logic [3:0] S_RUN_CMD  = 4'd8;
    localparam logic [3:0] S_RUN_WAIT = 4'd9;
    localparam logic [3:0] S_STATUS   = 4'd10;

    localparam logic [7:0] OP_WRITE    = 8'h01;
    localparam logic [7:0] OP_RUN      = 8'h02;
    localparam logic [7:0] OP_READ     = 8'h03;
    localparam logic [7:0] STAT_RUN    = 8'hD0;
    localparam logic [7:0] STAT_WR_ACK = 8'hA5;

`ifdef DPU_BRIDGE_ACK_EN
    localparam bit ACK_EN = 1'b1;
`else
    localparam bit ACK_EN = 1'b0;
`endif

    logic [3:0]        r_state;
    logic              r_is_wr;     // packet in flight is a WRITE (else READ)
    logic [1:0]        r_cnt;       // header byte index within a 3-byte field
    logic [15:0]       r_hdr;       // first two bytes of the current field
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_rem;       // bytes still to transfer
    logic [7:0]        r_wdata;
    logic [7:0]        r_out;       // read byte or status byte for the host
    logic              r_err;

    logic              w_in_xfer;
    logic [23:0]       w_field;     // little-endian field completed by in_data
    logic [LEN_W-1:0]  w_len;
    logic              w_last;      // current byte is the final one of the packet

    assign w_in_xfer = in_valid && in_ready;
    assign w_field   = {in_data, r_hdr};
    assign w_len     = LEN_W'(w_field);
    assign w_last    = (r_rem == LEN_W'(1));

    // Host and command-side handshakes decode straight from the state, so the
    // command fields only move on the edge that also takes cmd_ready.
    always_comb begin
        in_ready  = (r_state == S_IDLE)    || (r_state == S_HDR_ADDR) ||
                    (r_state == S_HDR_LEN) || (r_state == S_WR_DATA);
        out_valid = (r_state == S_RD_OUT)  || (r_state == S_STATUS);
        out_data  = r_out;
        cmd_valid = (r_state == S_WR_CMD)  || (r_state == S_RD_CMD) ||
                    (r_state == S_RUN_CMD);
        cmd_type  = 2'd0;
        cmd_addr  = r_addr;
        cmd_data  = 8'h00;
        if (r_state == S_RUN_CMD) begin
            cmd_type = 2'd1;
            cmd_addr = '0;
        end else if (r_state == S_RD_CMD) begin
            cmd_type = 2'd2;
        end else if (r_state == S_WR_CMD) begin
            cmd_data = r_wdata;
        end
        busy = (r_state != S_IDLE);
        err  = r_err;
    end

    // Packet parser and command sequencer; a reset anywhere drops the packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_is_wr <= 1'b0;
            r_cnt   <= 2'd0;
            r_hdr   <= 16'h0000;
            r_addr  <= '0;
            r_rem   <= '0;
            r_wdata <= 8'h00;
            r_out   <= 8'h00;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_in_xfer) begin
                        r_cnt <= 2'd0;
                        if (in_data == OP_WRITE) begin
                            r_is_wr <= 1'b1;
                            r_state <= S_HDR_ADDR;
                        end else if (in_data == OP_READ) begin
                            r_is_wr <= 1'b0;
                            r_state <= S_HDR_ADDR;
                        end else if (in_data == OP_RUN) begin
                            r_state <= S_RUN_CMD;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                S_HDR_ADDR: begin
                    if (w_in_xfer) begin
                        r_hdr <= {in_data, r_hdr[15:8]};
                        r_cnt <= r_cnt + 2'd1;
                        if (r_cnt == 2'd2) begin
                            r_addr  <= ADDR_W'(w_field);
                            r_cnt   <= 2'd0;
                            r_state <= S_HDR_LEN;
                        end
                    end
                end
                S_HDR_LEN: begin
                    if (w_in_xfer) begin
                        r_hdr <= {in_data, r_hdr[15:8]};
                        r_cnt <= r_cnt + 2'd1;
                        if (r_cnt == 2'd2) begin
                            r_cnt <= 2'd0;
                            r_rem <= w_len;
                            if (w_len == '0) begin
                                if (r_is_wr && ACK_EN) begin
                                    r_out   <= STAT_WR_ACK;
                                    r_state <= S_STATUS;
                                end else begin
                                    r_state <= S_IDLE;
                                end
                            end else if (r_is_wr) begin
                                r_state <= S_WR_DATA;
                            end else begin
                                r_state <= S_RD_CMD;
                            end
                        end
                    end
                end
                S_WR_DATA: begin
                    if (w_in_xfer) begin
                        r_wdata <= in_data;
                        r_state <= S_WR_CMD;
                    end
                end
                S_WR_CMD: begin
                    if (cmd_ready) begin
                        r_addr <= r_addr + ADDR_W'(1);
                        r_rem  <= r_rem - LEN_W'(1);
                        if (!w_last) begin
                            r_state <= S_WR_DATA;
                        end else if (ACK_EN) begin
                            r_out   <= STAT_WR_ACK;
                            r_state <= S_STATUS;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                S_RD_CMD: begin
                    if (cmd_ready) begin
                        r_state <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (rsp_valid) begin
                        r_out   <= rsp_data;
                        r_state <= S_RD_OUT;
                    end
                end
                S_RD_OUT: begin
                    if (out_ready) begin
                        r_addr  <= r_addr + ADDR_W'(1);
                        r_rem   <= r_rem - LEN_W'(1);
                        r_state <= w_last ? S_IDLE : S_RD_CMD;
                    end
                end
                S_RUN_CMD: begin
                    if (cmd_ready) begin
                        r_state <= S_RUN_WAIT;
                    end
                end
                S_RUN_WAIT: begin
                    if (dpu_done) begin
                        r_out   <= STAT_RUN;
                        r_state <= S_STATUS;
                    end
                end
                S_STATUS: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/dpu_cmd_bridge.md
DPU_CMD_BRIDGE -- requirements
Module: dpu_cmd_bridge

Interface
REQ-001 Parameter ADDR_W, default 24, width of cmd_addr and of the packet address field.
REQ-002 Parameter LEN_W, default 24, width of the packet length field.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 in_valid  input  1  host byte-stream valid.
REQ-006 in_ready  output  1  bridge accepts in_data this cycle.
REQ-007 in_data  input  8  host packet byte.
REQ-008 out_valid  output  1  response byte valid to host.
REQ-009 out_ready  input  1  host accepts out_data.
REQ-010 out_data  output  8  response byte.
REQ-011 cmd_valid  output  1  command to layer top valid.
REQ-012 cmd_ready  input  1  layer top accepts command.
REQ-013 cmd_type  output  2  0=write byte, 1=run, 2=read byte.
REQ-014 cmd_addr  output  ADDR_W  byte address.
REQ-015 cmd_data  output  8  write byte.
REQ-016 rsp_valid  input  1  read data valid from layer top.
REQ-017 rsp_data  input  8  read data byte.
REQ-018 dpu_done  input  1  layer run complete pulse.
REQ-019 busy  output  1  high whenever state is not IDLE.
REQ-020 err  output  1  sticky illegal-opcode flag.

Function
REQ-021 Packet: opcode byte, 3 address bytes little-endian, 3 length bytes little-endian, then payload; opcode 0x01 WRITE, 0x02 RUN (no address/length/payload), 0x03 READ.
REQ-022 States: IDLE, HDR_ADDR, HDR_LEN, WR_DATA, WR_CMD, RD_CMD, RD_WAIT, RD_OUT, RUN_CMD, RUN_WAIT, STATUS.
REQ-023 in_ready is high only in IDLE, HDR_ADDR, HDR_LEN, WR_DATA; a byte transfers when in_valid && in_ready.
REQ-024 IDLE: 0x01/0x03 -> HDR_ADDR; 0x02 -> RUN_CMD; any other opcode sets err, byte discarded, stay IDLE.
REQ-025 After the 3rd length byte: length 0 -> IDLE (STATUS when ACK enabled, WRITE only); WRITE -> WR_DATA; READ -> RD_CMD.
REQ-026 WR_DATA captures one byte -> WR_CMD; WR_CMD drives cmd_valid=1, type 0; on cmd_ready: address +1, remaining -1, then WR_DATA if remaining nonzero else IDLE/STATUS.
REQ-027 RD_CMD drives cmd_valid=1, type 2; on cmd_ready -> RD_WAIT; first rsp_valid captures rsp_data -> RD_OUT.
REQ-028 RD_OUT holds out_valid=1 with captured byte; on out_ready: address +1, remaining -1, RD_CMD if nonzero else IDLE.
REQ-029 RUN_CMD drives cmd_valid=1, type 1, addr 0, data 0; on cmd_ready -> RUN_WAIT; on dpu_done -> STATUS with status byte 0xD0.
REQ-030 STATUS holds out_valid=1 with status byte; on out_ready -> IDLE.
REQ-031 cmd_valid, cmd_type, cmd_addr, cmd_data SHALL remain stable from assertion until cmd_ready.
REQ-032 Address increments modulo 2^ADDR_W (0xFFFFFF+1 = 0x000000).
REQ-033 rsp_valid outside RD_WAIT and dpu_done outside RUN_WAIT are ignored.
REQ-034 Throughput: at most one command per two cycles; no pipelining of outstanding reads.

Reset
REQ-035 On rst_n low: state IDLE, cmd_valid 0, cmd_type 0, cmd_addr 0, cmd_data 0, out_valid 0, out_data 0, busy 0, err 0, in_ready 1 after release.
REQ-036 Reset mid-packet discards all partial header/payload state; no command is issued after release until a new opcode arrives.

Configuration
REQ-037 Macro DPU_BRIDGE_ACK_EN: when defined, each completed WRITE packet (including length 0) enters STATUS with status byte 0xA5; when undefined, WRITE returns directly to IDLE and emits nothing.

Verification
REQ-038 WRITE addr 0x000010 len 3 data 11,22,33 -> three type-0 commands, addr 0x10/0x11/0x12, data 0x11/0x22/0x33; 0xA5 out only with ACK enabled.
REQ-039 READ addr 0x0524DC len 2, rsp_data 0x7F then 0x80 with cmd_ready held low 5 cycles -> cmd stable during stall, out bytes 0x7F, 0x80, then IDLE.
REQ-040 RUN, dpu_done after 100 cycles -> one type-1 command, busy high throughout, out byte 0xD0, then busy 0.
REQ-041 WRITE addr 0xFFFFFF len 2 -> command addresses 0xFFFFFF then 0x000000.
REQ-042 Opcode 0x7E then valid READ len 1 -> err=1 stays set, READ completes normally.
REQ-043 rst_n low during WR_DATA of 4-byte WRITE -> cmd_valid 0 immediately, state IDLE, next byte decoded as opcode.
